// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the TinyMIPS operand-port arbiter.
package tinymips_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle between the requesters and the operand-port arbiter.
// The timeout strobe exists only when ARB_TIMEOUT_EN is defined.
interface mem_port_arbiter_if;
    import tinymips_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;
`ifdef ARB_TIMEOUT_EN
    logic             timeout;

    modport master (output req, output done, input gnt, input sel, input busy, input timeout);
    modport slave  (input req, input done, output gnt, output sel, output busy, output timeout);
`else
    modport master (output req, output done, input gnt, input sel, input busy);
    modport slave  (input req, input done, output gnt, output sel, output busy);
`endif

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Rotate-priority encoder: first set req bit scanning from ptr upward, mod N_REQ.
module rr_picker
    import tinymips_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    // Scan from the far end so the candidate closest to ptr is written last.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[ptr + SEL_W'(i)]) begin
                valid = 1'b1;
                idx   = ptr + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner arbiter for the shared operand port, with a one-cycle turnaround.
// Optional hold-limit revocation is enabled by defining ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no owner, waiting for any request
// GRANT   | owner sel holds the port until done, abandon or hold limit
// RELEASE | dead cycle after an owner leaves; mux select held
module mem_port_arbiter
    import tinymips_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input logic                clk,
    input logic                reset_n,
    mem_port_arbiter_if.slave  bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be within 2..255");
    end

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic             release_now;
    logic             limit;

    rr_picker u_picker (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign release_now = bus.done || !bus.req[sel_q];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       timeout_q;

    assign limit = (cnt_q == 8'(MAX_HOLD - 1));

    // Counter is zero outside GRANT, so it is already clear on GRANT entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= (state_d == GRANT) ? ((state_q == GRANT) ? cnt_q + 8'd1 : 8'd0) : 8'd0;
            timeout_q <= (state_q == GRANT) && limit && !release_now;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign limit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE, RELEASE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (release_now || limit) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + SEL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_HOLD=4; timeout
// scenario runs only when ARB_TIMEOUT_EN is defined).
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n  = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        #12;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.sel !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b sel=%b busy=%b, want 0000 00 0", bus.gnt, bus.sel, bus.busy);
        end
`ifdef ARB_TIMEOUT_EN
        checks++;
        if (bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout: got %b want 0", bus.timeout);
        end
`endif
        step();
        reset_n = 1'b1;
        step();
        bus.req = 4'b0100;
        step();
        checks++;
        if (bus.gnt !== 4'b0100 || bus.sel !== 2'b10 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: gnt=%b sel=%b busy=%b, want 0100 10 1", bus.gnt, bus.sel, bus.busy);
        end
        step();
        checks++;
        if (bus.gnt !== 4'b0100) begin
            errors++;
            $display("FAIL first_hold: gnt=%b want 0100", bus.gnt);
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.sel !== 2'b10) begin
            errors++;
            $display("FAIL first_release: gnt=%b busy=%b sel=%b, want 0000 0 10", bus.gnt, bus.busy, bus.sel);
        end
        step();
    endtask

    task automatic test_round_robin;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_gnt;
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << order[k];
            step();
            checks++;
            if (bus.gnt !== exp_gnt || bus.sel !== 2'(order[k])) begin
                errors++;
                $display("FAIL rr_grant[%0d]: gnt=%b sel=%0d, want %b %0d", k, bus.gnt, bus.sel, exp_gnt, order[k]);
            end
            step();
            checks++;
            if (bus.gnt !== exp_gnt || bus.sel !== 2'(order[k])) begin
                errors++;
                $display("FAIL rr_stable[%0d]: gnt=%b sel=%0d, want %b %0d", k, bus.gnt, bus.sel, exp_gnt, order[k]);
            end
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            checks++;
            if (bus.gnt !== 4'b0000 || bus.sel !== 2'(order[k])) begin
                errors++;
                $display("FAIL rr_gap[%0d]: gnt=%b sel=%0d, want 0000 %0d", k, bus.gnt, bus.sel, order[k]);
            end
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_abandon;
        do_reset();
        bus.req = 4'b0010;
        step();
        bus.req = 4'b1010;
        step();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL abandon_hold: gnt=%b want 0010", bus.gnt);
        end
        bus.req = 4'b1000;
        step();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abandon_release: gnt=%b busy=%b, want 0000 0", bus.gnt, bus.busy);
        end
        step();
        checks++;
        if (bus.gnt !== 4'b1000 || bus.sel !== 2'b11) begin
            errors++;
            $display("FAIL abandon_next: gnt=%b sel=%b, want 1000 11", bus.gnt, bus.sel);
        end
        bus.done = 1'b1;
        bus.req  = 4'b0000;
        step();
        bus.done = 1'b0;
        step();
    endtask

    task automatic test_done_idle;
        do_reset();
        bus.req = 4'b0100;
        step();
        bus.done = 1'b1;
        step();
        bus.req = 4'b0000;
        step();
        step();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.sel !== 2'b10) begin
            errors++;
            $display("FAIL done_idle: gnt=%b busy=%b sel=%b, want 0000 0 10", bus.gnt, bus.busy, bus.sel);
        end
        bus.done = 1'b0;
        bus.req  = 4'b1111;
        step();
        checks++;
        if (bus.gnt !== 4'b1000 || bus.sel !== 2'b11) begin
            errors++;
            $display("FAIL done_idle_ptr: gnt=%b sel=%b, want 1000 11", bus.gnt, bus.sel);
        end
        bus.done = 1'b1;
        bus.req  = 4'b0000;
        step();
        bus.done = 1'b0;
        step();
    endtask

    task automatic test_async_reset;
        do_reset();
        bus.req = 4'b0100;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.sel !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: gnt=%b sel=%b busy=%b, want 0000 00 0", bus.gnt, bus.sel, bus.busy);
        end
        bus.req = 4'b1000;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if (bus.gnt !== 4'b1000 || bus.sel !== 2'b11 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_grant: gnt=%b sel=%b busy=%b, want 1000 11 1", bus.gnt, bus.sel, bus.busy);
        end
        bus.done = 1'b1;
        bus.req  = 4'b0000;
        step();
        bus.done = 1'b0;
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        do_reset();
        bus.req = 4'b0101;
        step();
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (bus.gnt !== 4'b0001 || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold[%0d]: gnt=%b timeout=%b, want 0001 0", i, bus.gnt, bus.timeout);
            end
        end
        step();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_revoke: gnt=%b timeout=%b, want 0000 1", bus.gnt, bus.timeout);
        end
        step();
        checks++;
        if (bus.gnt !== 4'b0100 || bus.sel !== 2'b10 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_next: gnt=%b sel=%b timeout=%b, want 0100 10 0", bus.gnt, bus.sel, bus.timeout);
        end
        step();
        step();
        step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_done_at_limit: gnt=%b timeout=%b, want 0000 0", bus.gnt, bus.timeout);
        end
        step();
    endtask
`else
    task automatic test_hold_forever;
        do_reset();
        bus.req = 4'b0001;
        step();
        repeat (20) step();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_forever: gnt=%b busy=%b, want 0001 1", bus.gnt, bus.busy);
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        step();
    endtask
`endif

    initial begin
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        test_reset();
        test_round_robin();
        test_abandon();
        test_done_idle();
        test_async_reset();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold_forever();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single 8-bit memory/ALU operand port of the TinyMIPS datapath among four requesters. It drives the 2-bit select of the 4-input datapath mux and issues one-hot grants. A grant holds until the owner signals completion. A one-cycle turnaround separates consecutive owners, so the mux output never switches mid-transaction.

## Interface
- `MAX_HOLD`, default 16: maximum cycles one owner may hold the port (used only with the timeout feature); legal range 2..255.
- `clk`  input  1: rising-edge clock.
- `reset_n`  input  1: asynchronous, active-low reset.
- `req`  input  4: per-requester request, level; bit i = requester i; must stay high until `done` or abandon.
- `done`  input  1: the resource completed the current owner's transaction; sampled only in GRANT.
- `gnt`  output  4: one-hot grant, registered; all zero when no owner.
- `sel`  output  2: mux select = index of current/last owner, registered.
- `busy`  output  1: high while in GRANT.
- `timeout`  output  1: one-cycle pulse when a grant is revoked by the hold limit (only with `ARB_TIMEOUT_EN`).

## Operation
- Reset values: `gnt`=4'b0000, `sel`=2'b00, `busy`=0, `timeout`=0, state=IDLE, priority pointer `ptr`=0, hold counter=0.
- Pick rule: first set bit of `req` scanning `ptr`, `ptr`+1, … mod 4.
- IDLE:
  - No `req` bit set: stay in IDLE.
  - Any `req` bit set: winner w goes to GRANT; `gnt`[w]=1, `sel`=w, `busy`=1 next cycle.
- GRANT:
  - `gnt`, `sel`, and `ptr` are frozen.
  - Exit to RELEASE when `done`=1, or when `req`[w]=0 (abandon). `done` and abandon in the same cycle count as one release.
  - On exit: `gnt`=0, `busy`=0 next cycle; `ptr`=(w+1) mod 4.
- RELEASE (one dead cycle, `sel` unchanged):
  - If any `req` bit is set, pick with the updated `ptr` and go straight to GRANT.
  - Otherwise go to IDLE.
- `done` outside GRANT is ignored.
- Requests arriving while GRANT is held wait; they are not queued beyond the level of `req`.
- A requester that re-asserts immediately after release is served after every other pending requester.
- `sel` changes only on entry to GRANT. It holds its last value in IDLE and RELEASE.
- Asynchronous reset mid-GRANT: all outputs take reset values immediately; the transaction is lost.

## Timing
- Request-to-grant latency from IDLE: 1 cycle. `req` high at edge k gives `gnt` high after edge k+1.
- Hand-off latency: `done` sampled at edge k → `gnt` low after k+1 (RELEASE) → next owner's `gnt` high after k+2.
- Back-to-back throughput: one grant per (transaction length + 1) cycles.
- Hold counter: cleared on GRANT entry, increments every GRANT cycle.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - If the hold counter reaches `MAX_HOLD`-1 in GRANT without `done` or abandon, force RELEASE.
  - `timeout` pulses high in the cycle RELEASE is entered; `ptr` advances as for a normal release.
  - `done` in the same cycle as the limit is a normal release with no pulse.
- Undefined:
  - No counter and no `timeout` port; `MAX_HOLD` is ignored.
  - A grant is held indefinitely until `done` or abandon.

## Structure
- Shared package `tinymips_arb_pkg`:
  - state enum {IDLE, GRANT, RELEASE};
  - constants `N_REQ`=4 and `SEL_W`=2.
- Sub-module `rr_picker`: combinational rotate-priority encoder. Inputs `req[3:0]` and `ptr[1:0]`; outputs `valid` and `idx[1:0]`. The FSM, registers and counter stay in the top level.

## Test plan
- Reset, then `req`=4'b0100 at cycle 2 → `gnt`=4'b0100, `sel`=2'b10, `busy`=1 at cycle 3; `done` at cycle 5 → `gnt`=0 at cycle 6.
- `req`=4'b1111 held, `done` pulsed 2 cycles after each grant → grants in order 0,1,2,3,0, each separated by one zero-`gnt` cycle; `sel` stable during every grant.
- Owner 1 granted, `req`=4'b1010, owner drops `req`[1] without `done` → release, then owner 3 granted (not 1, not 0).
- `done` asserted in IDLE with `req`=0 → no state change, `gnt` stays 0, `ptr` unchanged.
- Assert `reset_n`=0 mid-GRANT, asynchronously between edges → `gnt`=0, `sel`=0, `busy`=0 without waiting for a clock edge. After release with `req`=4'b1000, `gnt`=4'b1000 one cycle later.
- With `ARB_TIMEOUT_EN`, `MAX_HOLD`=4: owner 0 holds with no `done` → `timeout`=1 and `gnt`=0 at the 4th GRANT cycle's following edge; owner 2 with pending `req` granted next cycle.
